hd6309_avalon_bridge: RTL

Parametrised HD6309 bus to Avalon-MM master bridge, successor to the basic CPU-side bridge. Samples the 6309 E/Q clocks through a configurable synchroniser, issues one Avalon read or write per CPU cycle, and holds MRDY low until the transfer completes. Supports pipelined reads via `readdatavalid`, optional write responses, a bus-timeout watchdog and error reporting. Sits between the 6309 pins and the SoC interconnect.

---
 rtl/hd6309_avalon_bridge.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/hd6309_avalon_bridge.sv
// HD6309 bus to Avalon-MM master bridge.
// One Avalon transfer per CPU cycle; MRDY stretches E until it completes.
module hd6309_avalon_bridge #(
    parameter int ADDR_WIDTH  = 16,
    parameter int SYNC_STAGES = 3,
    parameter int PIPELINED   = 0,
    parameter int WRITE_RESP  = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] master_address,
    output logic                  master_read,
    output logic                  master_write,
    output logic [7:0]            master_writedata,
    input  logic [7:0]            master_readdata,
    input  logic                  master_waitrequest,
    input  logic                  master_readdatavalid,
    input  logic                  master_writeresponsevalid,
    input  logic [1:0]            master_response,
    input  logic [ADDR_WIDTH-1:0] bus_address,
    input  logic [7:0]            bus_data_out,
    output logic [7:0]            bus_data_in,
    input  logic                  bus_rw,
    input  logic                  bus_e,
    input  logic                  bus_q,
    input  logic                  bus_bs,
    input  logic                  bus_ba,
    output logic                  bus_mrdy,
    input  logic                  bus_reset_n,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [7:0]            err_count,
    input  logic                  err_clear
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] e_sync, q_sync, r_sync;
    logic                   e_s, q_s, r_s;
    logic                   cstart, cinit, abort;

    logic                  rw_q, rw_n;
    logic [WDW-1:0]        wd, wd_n;
    logic                  rd_n, wr_n, mrdy_n, fail, timeout;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [7:0]            wdata_n, data_n;

    logic unused_bs;
    assign unused_bs = bus_bs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_sync <= '0;
            q_sync <= '0;
            r_sync <= '0;
        end else begin
            e_sync <= {e_sync[SYNC_STAGES-2:0], bus_e};
            q_sync <= {q_sync[SYNC_STAGES-2:0], bus_q};
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus_reset_n};
        end
    end

    assign e_s     = e_sync[SYNC_STAGES-1];
    assign q_s     = q_sync[SYNC_STAGES-1];
    assign r_s     = r_sync[SYNC_STAGES-1];
    assign cstart  = !e_s && q_s;
    assign cinit   = !e_s && !q_s;
    assign abort   = !r_s;
    assign timeout = (wd == WDW'(TIMEOUT - 1));

    always_comb begin
        state_n = state;
        rd_n    = master_read;
        wr_n    = master_write;
        addr_n  = master_address;
        wdata_n = master_writedata;
        data_n  = bus_data_in;
        rw_n    = rw_q;
        wd_n    = wd;
        fail    = 1'b0;
        if (abort) begin
            state_n = IDLE;
            rd_n    = 1'b0;
            wr_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cstart && !bus_ba) begin
                        state_n = REQ;
                        addr_n  = bus_address;
                        wdata_n = bus_data_out;
                        rw_n    = bus_rw;
                        rd_n    = bus_rw;
                        wr_n    = !bus_rw;
                        wd_n    = '0;
                    end
                end
                REQ: begin
                    wd_n = wd + 1'b1;
                    if (!master_waitrequest) begin
                        rd_n = 1'b0;
                        wr_n = 1'b0;
                        if (rw_q) begin
                            if (PIPELINED != 0) begin
                                state_n = RESP;
                            end else begin
                                state_n = DONE;
                                data_n  = master_readdata;
                                fail    = |master_response;
                            end
                        end else if (WRITE_RESP != 0) begin
                            state_n = RESP;
                        end else begin
                            state_n = DONE;
                        end
                    end else if (timeout) begin
                        rd_n    = 1'b0;
                        wr_n    = 1'b0;
                        state_n = DONE;
                        fail    = 1'b1;
                        if (rw_q) data_n = 8'hFF;
                    end
                end
                RESP: begin
                    wd_n = wd + 1'b1;
                    if (rw_q ? master_readdatavalid
                             : master_writeresponsevalid) begin
                        state_n = DONE;
                        fail    = |master_response;
                        if (rw_q) data_n = master_readdata;
                    end else if (timeout) begin
                        state_n = DONE;
                        fail    = 1'b1;
                        if (rw_q) data_n = 8'hFF;
                    end
                end
                DONE: begin
                    if (cinit) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
        mrdy_n = !(state_n == REQ || state_n == RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
            bus_data_in      <= '0;
            bus_mrdy         <= 1'b1;
            rw_q             <= 1'b0;
            wd               <= '0;
        end else begin
            state            <= state_n;
            master_read      <= rd_n;
            master_write     <= wr_n;
            master_address   <= addr_n;
            master_writedata <= wdata_n;
            bus_data_in      <= data_n;
            bus_mrdy         <= mrdy_n;
            rw_q             <= rw_n;
            wd               <= wd_n;
        end
    end

    // A new error outranks a simultaneous clear, so the count restarts at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err       <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (fail) begin
            err      <= 1'b1;
            err_addr <= master_address;
            if (err_clear)
                err_count <= 8'd1;
            else if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end else if (err_clear) begin
            err       <= 1'b0;
            err_count <= '0;
        end
    end

endmodule
